// File: rtl/matrix_pkg.sv
// Constants and FSM encoding shared by the Gram-matrix front end, the multiplier and the inverse stage.
package matrix_pkg;

  localparam int SAMPLE_DW    = 8;
  localparam int MATRIX_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLR    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/stream_buf.sv
// Sample-pair register file: synchronous write, combinational read, cleared by the async reset.
module stream_buf
  import matrix_pkg::*;
#(
  parameter int DEPTH = MATRIX_DEPTH,
  parameter int DW    = SAMPLE_DW,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_ena,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [2*DW-1:0] rd_data
);

  logic [2*DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ena) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/matrix_stream_tx.sv
// Streams buffered (a, b) sample pairs, one per cycle, into the serial Gram-matrix multiplier.
module matrix_stream_tx
  import matrix_pkg::*;
#(
  parameter int DEPTH = MATRIX_DEPTH,
  parameter int DW    = SAMPLE_DW,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          I_sys_clk,
  input  logic          I_sys_rstn,
  input  logic          I_wr_ena,
  input  logic [AW-1:0] I_wr_addr,
  input  logic [DW-1:0] I_wr_data_a,
  input  logic [DW-1:0] I_wr_data_b,
  input  logic [AW:0]   I_len,
  input  logic          I_start,
  input  logic          I_pause,
  output logic          O_busy,
  output logic          O_acc_clr,
  output logic          O_mult_ena,
  output logic [DW-1:0] O_channela,
  output logic [DW-1:0] O_channelb,
  output logic          O_done,
  output logic          O_err
);

  state_t          state;
  logic [AW:0]     len_r;
  logic [AW:0]     idx;
  logic [2*DW-1:0] rd_data;
  logic            buf_we;
  logic            len_ok;
  logic            last;

  // The buffer is frozen while a stream is in flight so the sent data stays coherent.
  assign buf_we = I_wr_ena && ((state == IDLE) || (state == DONE));
  assign len_ok = (I_len != '0) && (I_len <= (AW+1)'(DEPTH));
  assign last   = O_mult_ena && (idx == len_r);

  stream_buf #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_buf (
    .clk     (I_sys_clk),
    .rst_n   (I_sys_rstn),
    .wr_ena  (buf_we),
    .wr_addr (I_wr_addr),
    .wr_data ({I_wr_data_a, I_wr_data_b}),
    .rd_addr (idx[AW-1:0]),
    .rd_data (rd_data)
  );

  // State and outputs advance together: each register holds what is visible in the current cycle.
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      state      <= IDLE;
      len_r      <= '0;
      idx        <= '0;
      O_busy     <= 1'b0;
      O_acc_clr  <= 1'b0;
      O_mult_ena <= 1'b0;
      O_channela <= '0;
      O_channelb <= '0;
      O_done     <= 1'b0;
      O_err      <= 1'b0;
    end else begin
      O_acc_clr  <= 1'b0;
      O_mult_ena <= 1'b0;
      O_done     <= 1'b0;
      O_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (I_start) begin
            if (len_ok) begin
              state     <= CLR;
              len_r     <= I_len;
              idx       <= '0;
              O_busy    <= 1'b1;
              O_acc_clr <= 1'b1;
            end else begin
              O_err <= 1'b1;
            end
          end
        end
        CLR, STREAM: begin
          if (last) begin
            state  <= DONE;
            O_done <= 1'b1;
          end else begin
            state <= STREAM;
            if (!I_pause) begin
              {O_channela, O_channelb} <= rd_data;
              O_mult_ena <= 1'b1;
              idx        <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          O_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Scoreboard bench for matrix_stream_tx: expected pairs are queued at stimulus time and popped per valid sample.
module tb_matrix_stream_tx;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          I_sys_rstn;
  logic          I_wr_ena;
  logic [AW-1:0] I_wr_addr;
  logic [DW-1:0] I_wr_data_a;
  logic [DW-1:0] I_wr_data_b;
  logic [AW:0]   I_len;
  logic          I_start;
  logic          I_pause;
  logic          O_busy;
  logic          O_acc_clr;
  logic          O_mult_ena;
  logic [DW-1:0] O_channela;
  logic [DW-1:0] O_channelb;
  logic          O_done;
  logic          O_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb_q[$];
  int a11, a12, a21, a22;

  matrix_stream_tx #(.DEPTH(DEPTH), .DW(DW)) dut (
    .I_sys_clk   (clk),
    .I_sys_rstn  (I_sys_rstn),
    .I_wr_ena    (I_wr_ena),
    .I_wr_addr   (I_wr_addr),
    .I_wr_data_a (I_wr_data_a),
    .I_wr_data_b (I_wr_data_b),
    .I_len       (I_len),
    .I_start     (I_start),
    .I_pause     (I_pause),
    .O_busy      (O_busy),
    .O_acc_clr   (O_acc_clr),
    .O_mult_ena  (O_mult_ena),
    .O_channela  (O_channela),
    .O_channelb  (O_channelb),
    .O_done      (O_done),
    .O_err       (O_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int a, input int b);
    I_wr_ena    = 1'b1;
    I_wr_addr   = AW'(addr);
    I_wr_data_a = DW'(a);
    I_wr_data_b = DW'(b);
    tick();
    I_wr_ena = 1'b0;
  endtask

  task automatic push(input int a, input int b);
    sb_q.push_back({DW'(a), DW'(b)});
  endtask

  // Issues the start and leaves the caller in the CLR cycle.
  task automatic start_stream(input string tag, input int len);
    I_len   = (AW+1)'(len);
    I_start = 1'b1;
    tick();
    I_start = 1'b0;
    chk({tag, "_busy_clr"}, O_busy, 1);
    chk({tag, "_acc_clr"}, O_acc_clr, 1);
    chk({tag, "_ena_clr"}, O_mult_ena, 0);
  endtask

  // Entered in the first sample cycle; bit k of each pattern refers to sample cycle k.
  task automatic run_check(input string tag, input int n, input logic [15:0] ena_pat,
                           input logic [15:0] pause_pat, input logic [7:0] hold_a);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_ena"}, O_mult_ena, ena_pat[k]);
      chk({tag, "_busy"}, O_busy, 1);
      chk({tag, "_nodone"}, O_done, 0);
      if (!ena_pat[k]) chk({tag, "_hold"}, O_channela, hold_a);
      I_pause = pause_pat[k];
      tick();
    end
    I_pause = 1'b0;
    chk({tag, "_done"}, O_done, 1);
    chk({tag, "_busy_done"}, O_busy, 1);
    chk({tag, "_ena_done"}, O_mult_ena, 0);
    tick();
    chk({tag, "_done_off"}, O_done, 0);
    chk({tag, "_busy_off"}, O_busy, 0);
  endtask

  // Monitor: models the downstream accumulators and compares every valid pair against the scoreboard.
  always @(negedge clk) begin
    if (I_sys_rstn) begin
      if (O_acc_clr) begin
        a11 = 0; a12 = 0; a21 = 0; a22 = 0;
      end
      if (O_mult_ena) begin
        chk("ena_in_busy", O_busy, 1);
        if (sb_q.size() == 0) begin
          chk("sb_underflow", sb_q.size(), 1);
        end else begin
          logic [15:0] e;
          e = sb_q.pop_front();
          chk("ch_a", O_channela, e[15:8]);
          chk("ch_b", O_channelb, e[7:0]);
        end
        a11 += int'(O_channela) * int'(O_channela);
        a12 += int'(O_channela) * int'(O_channelb);
        a21 += int'(O_channelb) * int'(O_channela);
        a22 += int'(O_channelb) * int'(O_channelb);
      end
    end
  end

  initial begin
    I_sys_rstn  = 1'b0;
    I_wr_ena    = 1'b0;
    I_wr_addr   = '0;
    I_wr_data_a = '0;
    I_wr_data_b = '0;
    I_len       = '0;
    I_start     = 1'b0;
    I_pause     = 1'b0;
    tick();
    tick();
    chk("rst_busy", O_busy, 0);
    chk("rst_acc_clr", O_acc_clr, 0);
    chk("rst_ena", O_mult_ena, 0);
    chk("rst_cha", O_channela, 0);
    chk("rst_chb", O_channelb, 0);
    chk("rst_done", O_done, 0);
    chk("rst_err", O_err, 0);
    I_sys_rstn = 1'b1;
    tick();

    // Two-sample stream and the Gram sums it produces.
    wr(0, 1, 3);
    wr(1, 2, 4);
    push(1, 3); push(2, 4);
    start_stream("t1", 2);
    tick();
    run_check("t1", 2, 16'b11, 16'b0, 8'd0);
    chk("t1_a11", a11, 5);
    chk("t1_a12", a12, 11);
    chk("t1_a21", a21, 11);
    chk("t1_a22", a22, 25);

    // Pause for two cycles after the first sample.
    for (int i = 0; i < 4; i++) wr(i, 5 + i, 10 + i);
    for (int i = 0; i < 4; i++) push(5 + i, 10 + i);
    start_stream("t2", 4);
    tick();
    run_check("t2", 6, 16'b111001, 16'b000011, 8'd5);
    chk("t2_cha_after", O_channela, 8);

    // Illegal lengths are rejected.
    for (int r = 0; r < 2; r++) begin
      I_len   = (r == 0) ? '0 : (AW+1)'(DEPTH + 1);
      I_start = 1'b1;
      tick();
      I_start = 1'b0;
      chk("t3_err", O_err, 1);
      chk("t3_busy", O_busy, 0);
      chk("t3_ena", O_mult_ena, 0);
      tick();
      chk("t3_err_off", O_err, 0);
      chk("t3_busy2", O_busy, 0);
      chk("t3_ena2", O_mult_ena, 0);
    end

    // Start and write during a stream are ignored.
    push(5, 10); push(6, 11); push(7, 12);
    start_stream("t4", 3);
    I_start     = 1'b1;
    I_wr_ena    = 1'b1;
    I_wr_addr   = '0;
    I_wr_data_a = 8'd9;
    I_wr_data_b = 8'd9;
    tick();
    chk("t4_ena0", O_mult_ena, 1);
    chk("t4_err0", O_err, 0);
    tick();
    I_start  = 1'b0;
    I_wr_ena = 1'b0;
    chk("t4_ena1", O_mult_ena, 1);
    chk("t4_err1", O_err, 0);
    tick();
    chk("t4_ena2", O_mult_ena, 1);
    chk("t4_err2", O_err, 0);
    tick();
    chk("t4_done", O_done, 1);
    tick();
    chk("t4_busy_off", O_busy, 0);
    push(5, 10);
    start_stream("t4b", 1);
    tick();
    run_check("t4b", 1, 16'b1, 16'b0, 8'd0);

    // Reset in the middle of a full-depth stream.
    push(5, 10); push(6, 11);
    start_stream("t5", DEPTH);
    tick();
    tick();
    tick();
    chk("t5_ena_pre", O_mult_ena, 1);
    I_sys_rstn = 1'b0;
    #1;
    chk("t5_busy", O_busy, 0);
    chk("t5_ena", O_mult_ena, 0);
    chk("t5_cha", O_channela, 0);
    chk("t5_chb", O_channelb, 0);
    chk("t5_done", O_done, 0);
    tick();
    I_sys_rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_done", O_done, 0);
      chk("t5_idle", O_busy, 0);
    end
    push(0, 0);
    start_stream("t5b", 1);
    tick();
    run_check("t5b", 1, 16'b1, 16'b0, 8'd0);

    // Write and start in the same cycle.
    push(2, 5);
    I_wr_ena    = 1'b1;
    I_wr_addr   = '0;
    I_wr_data_a = 8'd2;
    I_wr_data_b = 8'd5;
    start_stream("t6", 1);
    I_wr_ena = 1'b0;
    tick();
    run_check("t6", 1, 16'b1, 16'b0, 8'd0);

    tick();
    tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
